apb_byte_bridge: RTL and testbench

Parametrised byte-serial to APB master bridge between the board-level byte-strobe interface (`data_in`/`data_sel`/`data_wr`/`apb_we`/`apb_re`) and the peripheral register banks (I2C master, I2C slave, UART). It assembles multi-byte addresses and write data from 8-bit strobes and issues single APB transfers on one of `NCH` channels. It adds read-back capture, per-channel selection, optional address auto-increment, a PREADY timeout and error and completion flags. It is the generalised successor of the fixed 8-bit, single-target strobe front end.

---
 rtl/apb_byte_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_apb_byte_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_byte_bridge.sv
// -----------------------------------------------------------------------------
// apb_byte_bridge
//
// Byte-serial to APB master bridge. Address and write data are assembled from
// 8-bit load strobes (MSB byte first). A rising edge on apb_we / apb_re then
// issues one APB transfer on the channel given by ch_sel. Read data is captured
// into data_out. A transfer ends on pready or after TIMEOUT ACCESS cycles.
// The address can optionally auto-increment after each good transfer.
//
// Parameters:
//   ADDR_BYTES - address bytes (AW = 8*ADDR_BYTES)
//   DATA_BYTES - data bytes    (DW = 8*DATA_BYTES)
//   NCH        - number of APB channels (>= 2), CW = $clog2(NCH)
//   AUTO_INC   - 1: address += ADDR_STEP after every error-free transfer
//   ADDR_STEP  - auto-increment step
//   TIMEOUT    - maximum ACCESS cycles waiting for pready (1..65535)
//
// Ports:
//   pclk, prst_n            - clock (rising edge), async active-low reset
//   data_in, data_sel       - byte to load; 0 = address byte, 1 = data byte
//   data_wr, apb_we, apb_re - level strobes, each acts on its rising edge
//   ch_sel                  - target channel, sampled with the request
//   psel, penable, pwrite,
//   paddr, pwdata           - APB master outputs (psel one-hot per channel)
//   prdata, pready, pslverr - per-channel APB slave returns
//   data_out                - last captured read data
//   busy                    - transfer in progress (FSM not IDLE)
//   done_if                 - one-cycle pulse when a transfer ends (ok or error)
//   err                     - last transfer failed (slave error or timeout)
//   drop_if                 - one-cycle pulse when a request was discarded
// -----------------------------------------------------------------------------
module apb_byte_bridge #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 1,
    parameter int NCH        = 2,
    parameter int AUTO_INC   = 0,
    parameter int ADDR_STEP  = 4,
    parameter int TIMEOUT    = 255,
    localparam int AW        = 8 * ADDR_BYTES,
    localparam int DW        = 8 * DATA_BYTES,
    localparam int CW        = $clog2(NCH)
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic [7:0]        data_in,
    input  logic              data_sel,
    input  logic              data_wr,
    input  logic              apb_we,
    input  logic              apb_re,
    input  logic [CW-1:0]     ch_sel,
    output logic [NCH-1:0]    psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [NCH*DW-1:0] prdata,
    input  logic [NCH-1:0]    pready,
    input  logic [NCH-1:0]    pslverr,
    output logic [DW-1:0]     data_out,
    output logic              busy,
    output logic              done_if,
    output logic              err,
    output logic              drop_if
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_r;

    // Edge-detection history and the post-reset arming flag
    logic            wr_q_r;
    logic            we_q_r;
    logic            re_q_r;
    logic            armed_r;

    logic            wr_edge_s;
    logic            we_edge_s;
    logic            re_edge_s;
    logic            req_s;
    logic            drop_s;

    // Byte-assembled address / data staging registers
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   data_r;
    logic            inc_s;

    // Latched transfer context
    logic [CW-1:0]   ch_r;
    logic [15:0]     cnt_r;

    // Output registers
    logic [NCH-1:0]  psel_r;
    logic            penable_r;
    logic            pwrite_r;
    logic [AW-1:0]   paddr_r;
    logic [DW-1:0]   pwdata_r;
    logic [DW-1:0]   data_out_r;
    logic            busy_r;
    logic            done_if_r;
    logic            err_r;
    logic            drop_if_r;

    // Channel decode and selected-channel return muxing
    logic [NCH-1:0]  onehot_s;
    logic            ch_ok_s;
    logic            sel_ready_s;
    logic            sel_err_s;
    logic [DW-1:0]   sel_rdata_s;

    // Registered history of every strobe input; armed_r masks the first
    // cycle after reset so a level already high at release is not an edge.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wr_q_r  <= 1'b0;
            we_q_r  <= 1'b0;
            re_q_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            wr_q_r  <= data_wr;
            we_q_r  <= apb_we;
            re_q_r  <= apb_re;
            armed_r <= 1'b1;
        end
    end

    // Rising-edge detection and request accept/drop decision
    always_comb begin
        wr_edge_s = armed_r & data_wr & ~wr_q_r;
        we_edge_s = armed_r & apb_we  & ~we_q_r;
        re_edge_s = armed_r & apb_re  & ~re_q_r;
        req_s     = we_edge_s | re_edge_s;
        if (state_r == S_IDLE) begin
            // Simultaneous write and read: the write wins, the read is lost
            drop_s = we_edge_s & re_edge_s;
        end else begin
            drop_s = req_s;
        end
    end

    // One-hot decode of ch_sel; no match means an out-of-range channel
    always_comb begin
        onehot_s = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (ch_sel == CW'(k)) begin
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
        ch_ok_s = |onehot_s;
    end

    // Pick pready / pslverr / prdata of the latched channel only
    always_comb begin
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        sel_rdata_s = {DW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (ch_r == CW'(k)) begin
                sel_ready_s = pready[k];
                sel_err_s   = pslverr[k];
                sel_rdata_s = prdata[k*DW +: DW];
            end else begin
                sel_ready_s = sel_ready_s;
                sel_err_s   = sel_err_s;
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

    // Auto-increment fires in the DONE cycle of an error-free transfer
    always_comb begin
        if ((AUTO_INC != 0) && (state_r == S_DONE) && !err_r) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
        end
    end

    // Address / data byte shifters; an explicit address load takes priority
    // over a coincident auto-increment because it expresses newer intent.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            addr_r <= {AW{1'b0}};
            data_r <= {DW{1'b0}};
        end else begin
            if (wr_edge_s && !data_sel) begin
                addr_r <= AW'({addr_r, data_in});
            end else if (inc_s) begin
                addr_r <= addr_r + AW'(ADDR_STEP);
            end
            if (wr_edge_s && data_sel) begin
                data_r <= DW'({data_r, data_in});
            end
        end
    end

    // APB master FSM with all bus and status outputs registered
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_r    <= S_IDLE;
            ch_r       <= {CW{1'b0}};
            cnt_r      <= 16'd0;
            psel_r     <= {NCH{1'b0}};
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= {AW{1'b0}};
            pwdata_r   <= {DW{1'b0}};
            data_out_r <= {DW{1'b0}};
            busy_r     <= 1'b0;
            done_if_r  <= 1'b0;
            err_r      <= 1'b0;
            drop_if_r  <= 1'b0;
        end else begin
            done_if_r <= 1'b0;
            drop_if_r <= drop_s;
            case (state_r)
                S_IDLE: begin
                    if (req_s) begin
                        if (ch_ok_s) begin
                            state_r   <= S_SETUP;
                            ch_r      <= ch_sel;
                            psel_r    <= onehot_s;
                            penable_r <= 1'b0;
                            pwrite_r  <= we_edge_s;
                            paddr_r   <= addr_r;
                            pwdata_r  <= data_r;
                            cnt_r     <= 16'd0;
                            busy_r    <= 1'b1;
                            err_r     <= 1'b0;
                        end else begin
                            // Bad channel: report completion with error, no bus cycle
                            err_r     <= 1'b1;
                            done_if_r <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    state_r   <= S_ACCESS;
                    penable_r <= 1'b1;
                    cnt_r     <= 16'd0;
                end
                S_ACCESS: begin
                    if (sel_ready_s) begin
                        state_r   <= S_DONE;
                        psel_r    <= {NCH{1'b0}};
                        penable_r <= 1'b0;
                        done_if_r <= 1'b1;
                        err_r     <= sel_err_s;
                        if (!pwrite_r) begin
                            data_out_r <= sel_rdata_s;
                        end
                    end else if (cnt_r == 16'(TIMEOUT - 1)) begin
                        state_r   <= S_DONE;
                        psel_r    <= {NCH{1'b0}};
                        penable_r <= 1'b0;
                        done_if_r <= 1'b1;
                        err_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    psel_r    <= {NCH{1'b0}};
                    penable_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign psel     = psel_r;
    assign penable  = penable_r;
    assign pwrite   = pwrite_r;
    assign paddr    = paddr_r;
    assign pwdata   = pwdata_r;
    assign data_out = data_out_r;
    assign busy     = busy_r;
    assign done_if  = done_if_r;
    assign err      = err_r;
    assign drop_if  = drop_if_r;

    apb_byte_bridge_chk #(
        .NCH (NCH)
    ) u_chk (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .psel    (psel_r),
        .penable (penable_r),
        .busy    (busy_r),
        .done_if (done_if_r)
    );

endmodule

// -----------------------------------------------------------------------------
// apb_byte_bridge_chk
//
// Protocol invariants of the bridge outputs.
// Ports: pclk, prst_n, and the observed psel / penable / busy / done_if.
// -----------------------------------------------------------------------------
module apb_byte_bridge_chk #(
    parameter int NCH = 2
) (
    input logic           pclk,
    input logic           prst_n,
    input logic [NCH-1:0] psel,
    input logic           penable,
    input logic           busy,
    input logic           done_if
);

    a_psel_onehot: assert property (@(posedge pclk) disable iff (!prst_n)
        $onehot0(psel));

    a_penable_needs_psel: assert property (@(posedge pclk) disable iff (!prst_n)
        penable |-> (|psel));

    a_idle_no_psel: assert property (@(posedge pclk) disable iff (!prst_n)
        !busy |-> (psel == {NCH{1'b0}}));

    a_done_not_enabled: assert property (@(posedge pclk) disable iff (!prst_n)
        done_if |-> !penable);

endmodule

// File: tb/tb_apb_byte_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_byte_bridge
//
// Directed bench for apb_byte_bridge configured with 1 address byte, 2 data
// bytes, 3 channels, auto-increment by 4 and an 8-cycle timeout. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_byte_bridge;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic [7:0]  data_in;
    logic        data_sel;
    logic        data_wr;
    logic        apb_we;
    logic        apb_re;
    logic [1:0]  ch_sel;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [47:0] prdata;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [15:0] data_out;
    logic        busy;
    logic        done_if;
    logic        err;
    logic        drop_if;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 pclk = ~pclk;

    apb_byte_bridge #(
        .ADDR_BYTES (1),
        .DATA_BYTES (2),
        .NCH        (3),
        .AUTO_INC   (1),
        .ADDR_STEP  (4),
        .TIMEOUT    (8)
    ) dut (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .data_in  (data_in),
        .data_sel (data_sel),
        .data_wr  (data_wr),
        .apb_we   (apb_we),
        .apb_re   (apb_re),
        .ch_sel   (ch_sel),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .data_out (data_out),
        .busy     (busy),
        .done_if  (done_if),
        .err      (err),
        .drop_if  (drop_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic load_byte(input logic sel, input logic [7:0] b);
        data_sel = sel;
        data_in  = b;
        data_wr  = 1'b1;
        @(negedge pclk);
        data_wr  = 1'b0;
        @(negedge pclk);
    endtask

    // Raise the request level for one sample; returns just after E0
    task automatic request(input logic we, input logic re, input logic [1:0] ch);
        ch_sel = ch;
        apb_we = we;
        apb_re = re;
        @(negedge pclk);
        apb_we = 1'b0;
        apb_re = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done_if !== 1'b1 && n < max) begin
            @(negedge pclk);
            n++;
        end
    endtask

    task automatic do_read(input logic [15:0] rdata, input logic [7:0] exp_addr);
        prdata[16 +: 16] = rdata;
        request(1'b0, 1'b1, 2'd1);
        chk("rd_paddr", 32'(paddr), 32'(exp_addr));
        chk("rd_psel_pwrite", 32'({psel, pwrite}), 32'h4);
        wait_done(10, lat);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data_out", 32'(data_out), 32'(rdata));
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        prst_n   = 1'b0;
        data_in  = 8'h00;
        data_sel = 1'b0;
        data_wr  = 1'b0;
        apb_we   = 1'b0;
        apb_re   = 1'b0;
        ch_sel   = 2'd0;
        prdata   = 48'h0;
        pready   = 3'b000;
        pslverr  = 3'b000;
        cyc(3);

        // Reset values
        chk("rst_bus", 32'({psel, penable, pwrite, paddr, pwdata}), 32'h0);
        chk("rst_flags", 32'({busy, done_if, err, drop_if}), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        prst_n = 1'b1;
        cyc(2);

        // Basic write: addr 0x1C, data 0x0003, channel 0, zero wait
        load_byte(1'b0, 8'h1C);
        load_byte(1'b1, 8'h03);
        pready = 3'b111;
        request(1'b1, 1'b0, 2'd0);
        chk("wr_setup", 32'({psel, penable, pwrite, busy}), 32'b001_0_1_1);
        chk("wr_paddr", 32'(paddr), 32'h1C);
        chk("wr_pwdata", 32'(pwdata), 32'h0003);
        cyc(1);
        chk("wr_access", 32'({psel, penable, done_if}), 32'b001_1_0);
        cyc(1);
        chk("wr_done", 32'({done_if, err, busy, psel, penable}), 32'b1_0_1_000_0);
        cyc(1);
        chk("wr_idle", 32'({done_if, busy}), 32'h0);
        // address auto-incremented to 0x20

        // Reads on channel 1 with auto-increment
        load_byte(1'b0, 8'h2C);
        do_read(16'h1234, 8'h2C);
        do_read(16'h5678, 8'h30);
        do_read(16'h9ABC, 8'h34);

        // Timeout: no pready, 8 ACCESS cycles, no increment
        pready = 3'b000;
        request(1'b1, 1'b0, 2'd0);
        chk("to_paddr", 32'(paddr), 32'h38);
        wait_done(20, lat);
        chk("to_latency", 32'(lat), 32'd9);
        chk("to_err", 32'(err), 32'h1);
        chk("to_data_out", 32'(data_out), 32'h9ABC);
        cyc(1);
        chk("to_idle", 32'(busy), 32'h0);

        // Recovery: same address, err clears on SETUP
        pready = 3'b001;
        request(1'b1, 1'b0, 2'd0);
        chk("rec_paddr", 32'(paddr), 32'h38);
        chk("rec_err_setup", 32'(err), 32'h0);
        wait_done(10, lat);
        chk("rec_done_err", 32'({lat[3:0], err}), 32'h4);
        cyc(1);
        // address now 0x3C

        // Read request while busy is dropped
        pready = 3'b000;
        request(1'b1, 1'b0, 2'd0);
        apb_re = 1'b1;
        cyc(1);
        chk("busy_drop", 32'({drop_if, penable}), 32'b11);
        apb_re = 1'b0;
        pready = 3'b001;
        cyc(1);
        chk("busy_done", 32'({drop_if, done_if, pwrite}), 32'b011);
        cyc(4);
        chk("busy_no_read", 32'(busy), 32'h0);
        // address now 0x40

        // Simultaneous write and read in IDLE: write runs, read dropped
        pready = 3'b111;
        request(1'b1, 1'b1, 2'd0);
        chk("sim_drop", 32'({drop_if, pwrite, busy}), 32'b111);
        chk("sim_paddr", 32'(paddr), 32'h40);
        wait_done(10, lat);
        chk("sim_latency", 32'(lat), 32'd2);
        cyc(3);
        chk("sim_no_read", 32'({busy, drop_if}), 32'h0);
        // address now 0x44

        // Slave error on a read: err set, data still captured, no increment
        prdata  = {16'h2222, 16'hBEEF, 16'h1111};
        pslverr = 3'b010;
        request(1'b0, 1'b1, 2'd1);
        chk("slv_paddr", 32'(paddr), 32'h44);
        wait_done(10, lat);
        chk("slv_err", 32'(err), 32'h1);
        chk("slv_data_out", 32'(data_out), 32'hBEEF);
        cyc(1);

        // Errors on other channels are ignored
        pslverr = 3'b110;
        request(1'b0, 1'b1, 2'd0);
        chk("oth_paddr_psel", 32'({paddr, psel}), 32'({8'h44, 3'b001}));
        wait_done(10, lat);
        chk("oth_err", 32'(err), 32'h0);
        chk("oth_data_out", 32'(data_out), 32'h1111);
        cyc(1);
        // address now 0x48

        // Out-of-range channel
        pslverr = 3'b000;
        request(1'b1, 1'b0, 2'd3);
        chk("badch", 32'({done_if, err, busy, psel}), 32'b1_1_0_000);
        cyc(1);
        chk("badch_after", 32'({done_if, busy, psel}), 32'h0);

        // Reset during ACCESS with apb_we held high
        pready = 3'b000;
        ch_sel = 2'd2;
        apb_we = 1'b1;
        cyc(2);
        chk("mid_access", 32'({psel, penable, paddr}), 32'({3'b100, 1'b1, 8'h48}));
        prst_n = 1'b0;
        #1;
        chk("mid_rst_bus", 32'({psel, penable, pwrite, paddr, pwdata}), 32'h0);
        chk("mid_rst_flags", 32'({busy, done_if, err, drop_if, data_out}), 32'h0);
        cyc(2);
        prst_n = 1'b1;
        cyc(4);
        chk("post_rst_held", 32'({busy, psel, done_if, drop_if}), 32'h0);
        apb_we = 1'b0;
        cyc(1);

        // After reset: addr_reg is 0, two data bytes shift in MSB first
        load_byte(1'b1, 8'hA5);
        load_byte(1'b1, 8'h5A);
        pready = 3'b001;
        request(1'b1, 1'b0, 2'd0);
        chk("post_rst_wr", 32'({busy, psel, paddr, pwdata}), 32'({1'b1, 3'b001, 8'h00, 16'hA55A}));
        wait_done(10, lat);
        chk("post_rst_latency", 32'(lat), 32'd2);
        cyc(1);

        // Address truncation to one byte: 0x04 -> 0x11 -> 0x50
        load_byte(1'b0, 8'h11);
        load_byte(1'b0, 8'h50);
        pready = 3'b100;
        request(1'b0, 1'b1, 2'd2);
        chk("trunc_paddr", 32'({paddr, psel}), 32'({8'h50, 3'b100}));
        wait_done(10, lat);
        chk("trunc_data_out", 32'({lat[3:0], data_out}), 32'h22222);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
